// File: rtl/module_pc_fetch.sv
// PC register and instruction-fetch stage: sequences the imem request/ack handshake,
// holds the fetched word for decode and selects the next PC on consumption.
module module_pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jalr_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misaligned_o,
  output logic [31:0] instr_count_o
);

  typedef enum logic [1:0] {StIdle, StWait, StValid} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        mis_q, mis_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_sel;
  logic        next_mis;
  logic        consume;

  assign pc_plus4 = pc_q + 32'd4;
  assign consume  = instr_ready_i & ~stall_i;

  // Misalignment is judged on the raw target, before any low bits are cleared.
  always_comb begin
    next_sel = pc_plus4;
    next_mis = 1'b0;
    unique case (pc_src_i)
      2'b01: begin
        next_sel = branch_target_i;
        next_mis = |branch_target_i[1:0];
      end
      2'b10: begin
        next_sel = jalr_target_i & ~32'h1;
        next_mis = |jalr_target_i[1:0];
      end
      default: begin
        next_sel = pc_plus4;
        next_mis = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    mis_d   = mis_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        state_d = StWait;
        req_d   = 1'b1;
      end
      StWait: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = StValid;
        end
      end
      StValid: begin
        if (consume) begin
          pc_d    = {next_sel[31:2], 2'b00};
          mis_d   = mis_q | next_mis;
          count_d = count_q + 32'd1;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = StWait;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
      count_q <= count_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign misaligned_o  = mis_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_module_pc_fetch.sv
// Directed bench for module_pc_fetch: a table of fetch/consume transactions plus
// hand-written reset sequences.
module tb_module_pc_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic [1:0]  pc_src_i;
  logic [31:0] branch_target_i;
  logic [31:0] jalr_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        misaligned_o;
  logic [31:0] instr_count_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_count;

  module_pc_fetch #(
    .RESET_VECTOR(32'h0000_0000),
    .NOP_INSTR   (Nop)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .pc_src_i       (pc_src_i),
    .branch_target_i(branch_target_i),
    .jalr_target_i  (jalr_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .misaligned_o   (misaligned_o),
    .instr_count_o  (instr_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned delay;
    logic [31:0] rdata;
    int unsigned stall;
    logic [1:0]  src;
    logic [31:0] br;
    logic [31:0] jalr;
    logic [31:0] next;
    logic        mis;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    for (int k = 0; k < 8 && imem_req_o !== 1'b1; k++) step();
    chk("req_seen", {31'd0, imem_req_o}, 32'd1);
    chk("fetch_addr", imem_addr_o, v.addr);
    chk("pc_plus4", pc_plus4_o, v.addr + 32'd4);
    // ready high while waiting must not consume anything
    instr_ready_i = 1'b1;
    for (int d = 0; d < int'(v.delay); d++) begin
      imem_ack_i = 1'b0;
      pc_src_i   = 2'b01;
      step();
      chk("wait_addr_stable", imem_addr_o, v.addr);
      chk("wait_valid_low", {31'd0, instr_valid_o}, 32'd0);
      chk("wait_count", instr_count_o, exp_count);
    end
    instr_ready_i = 1'b0;
    imem_ack_i    = 1'b1;
    imem_rdata_i  = v.rdata;
    step();
    chk("valid_after_ack", {31'd0, instr_valid_o}, 32'd1);
    chk("instr_after_ack", instr_o, v.rdata);
    chk("req_drop", {31'd0, imem_req_o}, 32'd0);
    // stray ack during VALID must be ignored
    imem_rdata_i  = ~v.rdata;
    stall_i       = 1'b1;
    instr_ready_i = 1'b1;
    for (int s = 0; s < int'(v.stall); s++) begin
      step();
      chk("stall_pc", pc_o, v.addr);
      chk("stall_instr", instr_o, v.rdata);
      chk("stall_count", instr_count_o, exp_count);
    end
    imem_ack_i      = 1'b0;
    stall_i         = 1'b0;
    pc_src_i        = v.src;
    branch_target_i = v.br;
    jalr_target_i   = v.jalr;
    step();
    instr_ready_i = 1'b0;
    exp_count     = exp_count + 32'd1;
    chk("next_pc", pc_o, v.next);
    chk("next_pc_plus4", pc_plus4_o, v.next + 32'd4);
    chk("count", instr_count_o, exp_count);
    chk("instr_nop", instr_o, Nop);
    chk("valid_cleared", {31'd0, instr_valid_o}, 32'd0);
    chk("misaligned", {31'd0, misaligned_o}, {31'd0, v.mis});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    chk({tag, "_instr"}, instr_o, Nop);
    chk({tag, "_mis"}, {31'd0, misaligned_o}, 32'd0);
    chk({tag, "_count"}, instr_count_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 0, 32'h0010_0093, 0, 2'b00, 32'h0, 32'h0, 32'h0000_0004, 1'b0};
    vecs[1] = '{32'h0000_0004, 0, 32'h0020_0113, 0, 2'b00, 32'h0, 32'h0, 32'h0000_0008, 1'b0};
    vecs[2] = '{32'h0000_0008, 0, 32'h0030_0193, 0, 2'b11, 32'h40, 32'h80, 32'h0000_000C, 1'b0};
    vecs[3] = '{32'h0000_000C, 3, 32'h0050_0093, 4, 2'b00, 32'h0, 32'h0, 32'h0000_0010, 1'b0};
    vecs[4] = '{32'h0000_0010, 1, 32'h0630_0063, 0, 2'b01, 32'h100, 32'h300, 32'h0000_0100, 1'b0};
    vecs[5] = '{32'h0000_0100, 0, 32'h0002_80E7, 0, 2'b10, 32'h500, 32'h205, 32'h0000_0204, 1'b1};
    vecs[6] = '{32'h0000_0204, 2, 32'hDEAD_BEEF, 1, 2'b01, 32'hFFFF_FFFC, 32'h0,
                32'hFFFF_FFFC, 1'b1};
    vecs[7] = '{32'hFFFF_FFFC, 0, 32'h1234_5678, 0, 2'b00, 32'h0, 32'h0, 32'h0000_0000, 1'b1};
    vecs[8] = '{32'h0000_0000, 0, 32'hCAFE_0001, 0, 2'b01, 32'h103, 32'h777, 32'h0000_0100,
                1'b1};

    rst_i = 1'b1; stall_i = 1'b0; pc_src_i = 2'b00; branch_target_i = 32'h0;
    jalr_target_i = 32'h0; imem_ack_i = 1'b0; imem_rdata_i = 32'h0; instr_ready_i = 1'b0;
    exp_count = 32'd0;
    step();
    step();
    chk_reset_state("reset");
    rst_i = 1'b0;
    // cycle 1 after release: still idle
    chk("cycle1_req", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("cycle2_req", {31'd0, imem_req_o}, 32'd1);
    chk("cycle2_addr", imem_addr_o, 32'h0);

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i]);
      if (i == 2) chk("count_three", instr_count_o, 32'd3);
    end

    // Reset coincident with ack in WAIT: acked data must be dropped.
    chk("pre_reset_req", {31'd0, imem_req_o}, 32'd1);
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hBAD0_BAD0;
    rst_i        = 1'b1;
    step();
    imem_ack_i = 1'b0;
    chk_reset_state("ack_reset");
    rst_i = 1'b0;
    step();
    chk("post_reset_req", {31'd0, imem_req_o}, 32'd1);
    exp_count = 32'd0;
    do_txn(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
